// File: rtl/usrxpack_if.sv
// rtl/usrxpack_if.sv - receiver-round input and packer-side output stream bundle for usrxpack
interface usrxpack_if #(
  parameter int NR = 4
);
  logic [NR*48-1:0] rx_tdata;
  logic             rx_tuser;
  logic             rx_tvalid;
  logic             rx_tready;
  logic [23:0]      us_tdata;
  logic             us_tlast;
  logic [1:0]       us_tuser;
  logic             us_tvalid;
  logic             us_tready;
  logic [10:0]      us_tlength;

  modport slave (
    input  rx_tdata, rx_tuser, rx_tvalid,
    output rx_tready,
    output us_tdata, us_tlast, us_tuser, us_tvalid, us_tlength,
    input  us_tready
  );

  modport master (
    output rx_tdata, rx_tuser, rx_tvalid,
    input  rx_tready,
    input  us_tdata, us_tlast, us_tuser, us_tvalid, us_tlength,
    output us_tready
  );
endinterface

// File: rtl/usrxpack.sv
// rtl/usrxpack.sv - serializes receiver I/Q rounds atomically into a FWFT word FIFO
// Optional saturating drop counter on ovf_cnt enabled by macro USRXPACK_OVF_CNT_EN.
module usrxpack #(
  parameter int NR    = 4,
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [4:0]  nrx,
  usrxpack_if.slave   bus,
  output logic [15:0] ovf_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = NR * 48;
  localparam int BW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, SERIAL, FLUSH} state_t;

  state_t          state_q, state_d;
  logic            rx_tready_q, rx_tready_d;
  logic [DW-1:0]   data_q, data_d;
  logic            vna_q, vna_d;
  logic [4:0]      nwords_q, nwords_d;
  logic [4:0]      idx_q, idx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [10:0]     count_q, count_d;

  logic [5:0]      n_req, n_eff;
  logic [4:0]      words_w;
  logic            fits, hs, pop, wr_en, last_w;
  logic [BW-1:0]   sel_base;
  logic [26:0]     wr_word, rd_word;
  logic [26:0]     mem_q [DEPTH];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    n_req    = {1'b0, nrx} + 6'd1;
    n_eff    = (n_req > 6'(NR)) ? 6'(NR) : n_req;
    words_w  = 5'({n_eff, 1'b0});
    fits     = ({1'b0, count_q} + 12'(words_w)) <= 12'(DEPTH);
    hs       = (state_q == IDLE) && rx_tready_q && run && bus.rx_tvalid;
    pop      = (count_q != 11'd0) && bus.us_tready;
    wr_en    = (state_q == SERIAL) && run;
    last_w   = (idx_q == nwords_q - 5'd1);
    // Even word indices take the I half (upper 24 bits) of the receiver's 48-bit slot.
    sel_base = BW'(24 * int'(idx_q ^ 5'd1));
    wr_word  = {last_w, (idx_q == 5'd0), vna_q, data_q[sel_base +: 24]};

    state_d  = state_q;
    data_d   = data_q;
    vna_d    = vna_q;
    nwords_d = nwords_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          data_d   = bus.rx_tdata;
          vna_d    = bus.rx_tuser;
          nwords_d = words_w;
          idx_d    = 5'd0;
          if (fits) state_d = SERIAL;
        end
      end
      SERIAL: begin
        idx_d = idx_q + 5'd1;
        if (last_w) state_d = IDLE;
      end
      FLUSH: begin
        if (run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!run) state_d = FLUSH;
    rx_tready_d = (state_d == IDLE);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (state_q == FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 11'd0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + 11'd1;
        2'b01:   count_d = count_q - 11'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_tready_q <= 1'b0;
      data_q      <= '0;
      vna_q       <= 1'b0;
      nwords_q    <= 5'd0;
      idx_q       <= 5'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 11'd0;
    end else begin
      state_q     <= state_d;
      rx_tready_q <= rx_tready_d;
      data_q      <= data_d;
      vna_q       <= vna_d;
      nwords_q    <= nwords_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  // Read data is masked by valid so stale RAM contents never leak after reset or flush.
  assign rd_word        = mem_q[rd_ptr_q];
  assign bus.rx_tready  = rx_tready_q;
  assign bus.us_tvalid  = (count_q != 11'd0);
  assign bus.us_tlength = count_q;
  assign bus.us_tdata   = bus.us_tvalid ? rd_word[23:0] : 24'd0;
  assign bus.us_tlast   = bus.us_tvalid ? rd_word[26]   : 1'b0;
  assign bus.us_tuser   = bus.us_tvalid ? rd_word[25:24] : 2'b00;

`ifdef USRXPACK_OVF_CNT_EN
  logic        ovf_inc;
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_inc = hs && !fits;
    ovf_d   = (ovf_inc && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 16'd0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_usrxpack.sv
// tb/tb_usrxpack.sv - scoreboard bench for usrxpack: ordering, backpressure fill, flush and reset
module tb_usrxpack;
  localparam int NR    = 4;
  localparam int DEPTH = 1024;
`ifdef USRXPACK_OVF_CNT_EN
  localparam logic [15:0] OVF1 = 16'd1;
`else
  localparam logic [15:0] OVF1 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [4:0]  nrx = 5'd0;
  logic [15:0] ovf_cnt;

  usrxpack_if #(.NR(NR)) bus ();

  usrxpack #(.NR(NR), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .nrx     (nrx),
    .bus     (bus),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic [1:0]  user;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   passes  = 0;
  int   popped  = 0;
  int   max_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [23:0] wv(input int r, input int w);
    logic [23:0] t;
    t = 24'(r * 24 + w);
    return t ^ 24'h5A5000;
  endfunction

  function automatic logic [NR*48-1:0] mk(input int r);
    logic [NR*48-1:0] d;
    d = '0;
    for (int k = 0; k < NR; k++) begin
      d[48*k+24 +: 24] = wv(r, 2*k);
      d[48*k +: 24]    = wv(r, 2*k+1);
    end
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Offers one round and returns 2 ns after the handshake edge; pushes expectations if accepted.
  task automatic send(input logic [NR*48-1:0] d, input logic [4:0] n, input logic u, input bit accept);
    bit ok;
    int ne;
    exp_t e;
    ok = 1'b0;
    bus.rx_tdata  = d;
    bus.rx_tuser  = u;
    nrx           = n;
    bus.rx_tvalid = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (bus.rx_tready) begin
        @(posedge clk);
        #2;
        ok = 1'b1;
      end
    end
    bus.rx_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL handshake_timeout: got no rx_tready expected handshake");
    end else if (accept) begin
      ne = int'(n) + 1;
      if (ne > NR) ne = NR;
      for (int w = 0; w < 2*ne; w++) begin
        e.data = (w % 2 == 0) ? d[48*(w/2)+24 +: 24] : d[48*(w/2) +: 24];
        e.last = (w == 2*ne - 1);
        e.user = {(w == 0), u};
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && (sb.size() != 0 || bus.us_tvalid); i++) @(negedge clk);
    chk(name, sb.size(), 0);
    chk({name, "_tvalid"}, bus.us_tvalid, 1'b0);
    tick;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_us_tvalid"},  bus.us_tvalid,  1'b0);
    chk({tag, "_us_tlength"}, bus.us_tlength, 11'd0);
    chk({tag, "_us_tlast"},   bus.us_tlast,   1'b0);
    chk({tag, "_us_tuser"},   bus.us_tuser,   2'd0);
    chk({tag, "_us_tdata"},   bus.us_tdata,   24'd0);
    chk({tag, "_rx_tready"},  bus.rx_tready,  1'b0);
    chk({tag, "_ovf_cnt"},    ovf_cnt,        16'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (int'(bus.us_tlength) > max_len) max_len = int'(bus.us_tlength);
      if (rst_n && bus.us_tvalid && bus.us_tready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", bus.us_tdata);
        end else begin
          e = sb.pop_front();
          chk("us_tdata", bus.us_tdata, e.data);
          chk("us_tlast", bus.us_tlast, e.last);
          chk("us_tuser", bus.us_tuser, e.user);
          popped++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*48-1:0] d;
    bus.rx_tdata  = '0;
    bus.rx_tuser  = 1'b0;
    bus.rx_tvalid = 1'b0;
    bus.us_tready = 1'b0;

    #12;
    chk_zero_outputs("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    chk("rx_tready_before_edge", bus.rx_tready, 1'b0);
    tick;
    @(negedge clk);
    chk("rx_tready_after_edge", bus.rx_tready, 1'b1);

    // Two receivers, hand-computed words.
    tick;
    d = '0;
    d[47:24]   = 24'h111111;
    d[23:0]    = 24'h222222;
    d[95:72]   = 24'h333333;
    d[71:48]   = 24'h444444;
    d[143:96]  = 48'hDEAD01_BEEF02;
    d[191:144] = 48'hCAFE03_F00D04;
    send(d, 5'd1, 1'b1, 1'b1);
    repeat (4) tick;
    @(negedge clk);
    chk("t1_tlength", bus.us_tlength, 11'd4);
    chk("t1_tvalid", bus.us_tvalid, 1'b1);
    chk("t1_head_data", bus.us_tdata, 24'h111111);
    chk("t1_head_user", bus.us_tuser, 2'b11);
    chk("t1_head_last", bus.us_tlast, 1'b0);
    tick;
    bus.us_tready = 1'b1;
    wait_drain("t1_drain", 50);

    // nrx beyond NR clamps to 8 words; tready low for exactly 8 cycles.
    send(mk(1), 5'd15, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_tready_low", bus.rx_tready, 1'b0);
    end
    @(negedge clk);
    chk("t2_tready_high", bus.rx_tready, 1'b1);
    tick;
    send(mk(2), 5'd31, 1'b1, 1'b1);
    send(mk(3), 5'd0, 1'b0, 1'b1);
    send(mk(4), 5'd2, 1'b1, 1'b1);
    wait_drain("t2_drain", 100);
    bus.us_tready = 1'b0;

    // Fill under backpressure with 4-word rounds.
    max_len = 0;
    for (int r = 0; r < 255; r++) send(mk(100 + r), 5'd1, r[0], 1'b1);
    repeat (5) tick;
    @(negedge clk);
    chk("t3_len_1020", bus.us_tlength, 11'd1020);
    tick;
    send(mk(355), 5'd1, 1'b0, 1'b1);
    repeat (5) tick;
    @(negedge clk);
    chk("t3_len_1024", bus.us_tlength, 11'd1024);
    chk("t3_ovf_before", ovf_cnt, 16'd0);
    tick;
    send(mk(356), 5'd1, 1'b1, 1'b0);
    repeat (3) tick;
    @(negedge clk);
    chk("t3_ovf_after", ovf_cnt, OVF1);
    chk("t3_len_full", bus.us_tlength, 11'd1024);
    chk("t3_tready_idle", bus.rx_tready, 1'b1);
    chk("t3_max_len", max_len <= DEPTH, 1'b1);
    tick;
    bus.us_tready = 1'b1;
    wait_drain("t3_drain", 3000);

    // Continuous streaming past pointer wrap.
    max_len = 0;
    popped  = 0;
    for (int r = 0; r < 400; r++) send(mk(1000 + r), 5'd3, r[1], 1'b1);
    wait_drain("t4_drain", 200);
    chk("t4_popped", popped, 3200);
    chk("t4_max_len", max_len <= 8, 1'b1);
    chk("t4_ovf", ovf_cnt, OVF1);
    bus.us_tready = 1'b0;

    // run dropped on the third word of a round.
    send(mk(2000), 5'd3, 1'b0, 1'b0);
    tick;
    tick;
    run = 1'b0;
    @(negedge clk);
    chk("t5_len_two", bus.us_tlength, 11'd2);
    tick;
    @(negedge clk);
    chk("t5_flush_tready", bus.rx_tready, 1'b0);
    chk("t5_no_third_word", bus.us_tlength, 11'd2);
    tick;
    @(negedge clk);
    chk("t5_tvalid_cleared", bus.us_tvalid, 1'b0);
    chk("t5_len_cleared", bus.us_tlength, 11'd0);
    tick;
    bus.rx_tdata  = mk(2002);
    bus.rx_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_tready", bus.rx_tready, 1'b0);
      chk("t5_hold_len", bus.us_tlength, 11'd0);
    end
    tick;
    bus.rx_tvalid = 1'b0;
    run = 1'b1;
    tick;
    @(negedge clk);
    chk("t5_resume_tready", bus.rx_tready, 1'b1);
    chk("t5_ovf", ovf_cnt, OVF1);
    tick;
    bus.us_tready = 1'b1;
    send(mk(2001), 5'd3, 1'b1, 1'b1);
    wait_drain("t5_drain", 100);
    bus.us_tready = 1'b0;

    // Asynchronous reset in the middle of a round.
    send(mk(3000), 5'd3, 1'b0, 1'b0);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    repeat (2) tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_tready_release", bus.rx_tready, 1'b0);
    tick;
    bus.us_tready = 1'b1;
    send(mk(3001), 5'd1, 1'b1, 1'b1);
    wait_drain("t6_drain", 100);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
